// File: rtl/gbf_pkg.sv
// Shared types and default sizes for the GBF read path.
package gbf_pkg;

  localparam int GBF_DATA_WIDTH = 96;
  localparam int GBF_ADDR_W     = 20;
  localparam int GBF_GRP_W      = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    GRP_DONE = 2'd2,
    LAY_DONE = 2'd3
  } gbf_state_e;

endpackage

// File: rtl/gbf_rd_fifo2.sv
// Two-entry valid/ready buffer between the SRAM read port and the stream output.
// A flush empties it and takes priority over a simultaneous write.
module gbf_rd_fifo2 #(
  parameter int W = 96
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_dat_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o,
  input  logic         rdy_i,
  output logic [1:0]   cnt_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;
  logic         push;
  logic         pop;

  assign vld_o = (cnt_q != 2'd0);
  assign dat_o = mem_q[rd_ptr_q];
  assign cnt_o = cnt_q;
  assign pop   = vld_o & rdy_i;
  // The producer never overfills, but a full buffer still refuses a write.
  assign push  = wr_en_i & ((cnt_q != 2'd2) | pop);

  // Storage, pointers and occupancy; entries are only overwritten once popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/gbf_ftrgrp_reader.sv
// Streams one feature group of GBF words at a time out of SRAM. A base-address
// table marks group boundaries; layer/group pulses restart, replay or advance.
module gbf_ftrgrp_reader
  import gbf_pkg::*;
#(
  parameter int DATA_WIDTH = GBF_DATA_WIDTH,
  parameter int ADDR_W     = GBF_ADDR_W,
  parameter int GRP_W      = GBF_GRP_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Reset_FtrLay,
  input  logic                  Reset_FtrGrp,
  input  logic                  Next_FtrGrp,
  input  logic                  cfg_wr_en,
  input  logic [GRP_W-1:0]      cfg_wr_idx,
  input  logic [ADDR_W-1:0]     cfg_wr_base,
  input  logic [GRP_W-1:0]      cfg_num_grp,
  output logic                  sram_rd_en,
  output logic [ADDR_W-1:0]     sram_rd_addr,
  input  logic [DATA_WIDTH-1:0] sram_rd_dat,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_dat,
  input  logic                  out_rdy,
  output logic                  grp_done,
  output logic                  lay_done,
  output logic [GRP_W-1:0]      cnt_ftrgrp
);

  localparam int TAB_DEPTH = 2 ** GRP_W;

  logic [ADDR_W-1:0] tab_q [TAB_DEPTH];
  gbf_state_e        state_q;
  logic [GRP_W-1:0]  grp_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              pend_q;
  logic              disc_q;
  logic              grp_done_q;
  logic              lay_done_q;

  logic [GRP_W-1:0]  grp_inc;
  logic [ADDR_W-1:0] grp_base;
  logic [ADDR_W-1:0] grp_end;
  logic [1:0]        fifo_cnt;
  logic [1:0]        fifo_after;
  logic [1:0]        occ;
  logic              pop;
  logic              in_grp;
  logic              acc_lay;
  logic              acc_nxt;
  logic              acc_rep;
  logic              flush;
  logic              issue;
  logic              drained;
  logic              has_next;
  logic              fifo_wr;

  // Pulse arbitration, read issue and end-of-group detection.
  always_comb begin
    grp_inc    = grp_q + 1'b1;
    grp_base   = tab_q[grp_q];
    grp_end    = tab_q[grp_inc];
    pop        = out_vld & out_rdy;
    // Occupancy after this cycle's pop plus the word returning from SRAM;
    // counting the pop lets the pipe sustain one beat per cycle.
    fifo_after = fifo_cnt - {1'b0, pop};
    occ        = fifo_after + {1'b0, pend_q};
    in_grp     = (state_q == STREAM) || (state_q == GRP_DONE);
    acc_lay    = Reset_FtrLay;
    acc_nxt    = !acc_lay && Next_FtrGrp && in_grp;
    acc_rep    = !acc_lay && !acc_nxt && Reset_FtrGrp && in_grp;
    flush      = acc_lay || acc_nxt || acc_rep;
    issue      = (state_q == STREAM) && (rd_addr_q != grp_end) && (occ < 2'd2);
    drained    = (state_q == STREAM) && (rd_addr_q == grp_end) && !pend_q
                 && (fifo_after == 2'd0);
    has_next   = ({1'b0, grp_q} + 1'b1) < {1'b0, cfg_num_grp};
    fifo_wr    = pend_q & ~disc_q;
  end

  assign sram_rd_en   = issue;
  assign sram_rd_addr = rd_addr_q;
  assign grp_done     = grp_done_q;
  assign lay_done     = lay_done_q;
  assign cnt_ftrgrp   = grp_q;

  // Group base-address table, written by configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAB_DEPTH; i++) begin
        tab_q[i] <= '0;
      end
    end else if (cfg_wr_en) begin
      tab_q[cfg_wr_idx] <= cfg_wr_base;
    end
  end

  // Control FSM with address counter, in-flight/discard tracking and done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grp_q      <= '0;
      rd_addr_q  <= '0;
      pend_q     <= 1'b0;
      disc_q     <= 1'b0;
      grp_done_q <= 1'b0;
      lay_done_q <= 1'b0;
    end else begin
      grp_done_q <= (state_q == GRP_DONE);
      lay_done_q <= (state_q == LAY_DONE);
      pend_q     <= issue;
      // A word requested in the cycle a pulse is accepted belongs to the old stream.
      disc_q     <= issue & flush;
      if (acc_lay) begin
        grp_q     <= '0;
        rd_addr_q <= tab_q[0];
        state_q   <= STREAM;
      end else if (acc_nxt) begin
        if (has_next) begin
          grp_q     <= grp_inc;
          rd_addr_q <= grp_end;
          state_q   <= STREAM;
        end else begin
          state_q <= LAY_DONE;
        end
      end else if (acc_rep) begin
        rd_addr_q <= grp_base;
        state_q   <= STREAM;
      end else begin
        if (issue) begin
          rd_addr_q <= rd_addr_q + 1'b1;
        end
        if (drained) begin
          state_q <= GRP_DONE;
        end
      end
    end
  end

  gbf_rd_fifo2 #(
    .W(DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .wr_en_i (fifo_wr),
    .wr_dat_i(sram_rd_dat),
    .vld_o   (out_vld),
    .dat_o   (out_dat),
    .rdy_i   (out_rdy),
    .cnt_o   (fifo_cnt)
  );

endmodule

// File: tb/tb_gbf_ftrgrp_reader.sv
// Self-checking bench for gbf_ftrgrp_reader: directed vector tables of group
// operations plus hand-written latency, mid-stream, backpressure and reset runs.
module tb_gbf_ftrgrp_reader;

  localparam int DW = 96;
  localparam int AW = 20;
  localparam int GW = 10;

  typedef struct {
    logic [2:0] ops;    // {Reset_FtrLay, Next_FtrGrp, Reset_FtrGrp}
    int         first;  // first expected word address
    int         n;      // expected beat count
    int         grp;    // expected cnt_ftrgrp
    bit         lay;    // expected lay_done
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          Reset_FtrLay = 1'b0;
  logic          Reset_FtrGrp = 1'b0;
  logic          Next_FtrGrp = 1'b0;
  logic          cfg_wr_en = 1'b0;
  logic [GW-1:0] cfg_wr_idx = '0;
  logic [AW-1:0] cfg_wr_base = '0;
  logic [GW-1:0] cfg_num_grp = '0;
  logic          sram_rd_en;
  logic [AW-1:0] sram_rd_addr;
  logic [DW-1:0] sram_rd_dat = '0;
  logic          out_vld;
  logic [DW-1:0] out_dat;
  logic          out_rdy = 1'b1;
  logic          grp_done;
  logic          lay_done;
  logic [GW-1:0] cnt_ftrgrp;

  int            n_chk = 0;
  int            n_pass = 0;
  logic [DW-1:0] beats[$];
  bit            chk_bp = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_dat = '0;
  int            stall_err = 0;
  int            issued = 0;
  int            popped = 0;
  int            max_out = 0;

  always #5 clk = ~clk;

  gbf_ftrgrp_reader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Reset_FtrLay(Reset_FtrLay),
    .Reset_FtrGrp(Reset_FtrGrp),
    .Next_FtrGrp (Next_FtrGrp),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_wr_idx  (cfg_wr_idx),
    .cfg_wr_base (cfg_wr_base),
    .cfg_num_grp (cfg_num_grp),
    .sram_rd_en  (sram_rd_en),
    .sram_rd_addr(sram_rd_addr),
    .sram_rd_dat (sram_rd_dat),
    .out_vld     (out_vld),
    .out_dat     (out_dat),
    .out_rdy     (out_rdy),
    .grp_done    (grp_done),
    .lay_done    (lay_done),
    .cnt_ftrgrp  (cnt_ftrgrp)
  );

  function automatic logic [DW-1:0] word(input int a);
    logic [31:0] x;
    x = a;
    return {x ^ 32'h5A5A_0000, ~x, x};
  endfunction

  // SRAM model: data valid one cycle after a read, garbage otherwise.
  always @(posedge clk) begin
    sram_rd_dat <= sram_rd_en ? word(int'(sram_rd_addr)) : {3{32'hDEAD_BEEF}};
  end

  // Beat capture, stall stability and outstanding-read tracking.
  always @(negedge clk) begin
    if (!chk_bp) begin
      issued = 0; popped = 0; max_out = 0; stall_err = 0;
    end
    if (rst_n) begin
      if (out_vld && out_rdy) beats.push_back(out_dat);
      if (chk_bp) begin
        if (prev_stall && (!out_vld || out_dat != prev_dat)) stall_err++;
        if (sram_rd_en) issued++;
        if (out_vld && out_rdy) popped++;
        if (issued - popped > max_out) max_out = issued - popped;
      end
      prev_stall = out_vld && !out_rdy;
      prev_dat   = out_dat;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input int idx, input int base);
    cfg_wr_en = 1'b1; cfg_wr_idx = GW'(idx); cfg_wr_base = AW'(base);
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic set_tab(input int a0, input int a1, input int a2, input int a3, input int num);
    cfg_wr(0, a0); cfg_wr(1, a1); cfg_wr(2, a2); cfg_wr(3, a3);
    cfg_num_grp = GW'(num);
  endtask

  task automatic pulse(input logic [2:0] ops);
    {Reset_FtrLay, Next_FtrGrp, Reset_FtrGrp} = ops;
    tick();
    {Reset_FtrLay, Next_FtrGrp, Reset_FtrGrp} = 3'b000;
    beats.delete();
  endtask

  task automatic wait_done(input bit bp, input string name);
    int cyc = 0;
    logic [3:0] pat = 4'b1001;
    while (!(grp_done || lay_done) && cyc < 400) begin
      out_rdy = bp ? pat[cyc % 4] : 1'b1;
      tick();
      cyc++;
    end
    out_rdy = 1'b1;
    chk({name, " done"}, DW'(grp_done | lay_done), DW'(1));
  endtask

  task automatic run_op(input logic [2:0] ops, input int first, input int n, input int grp,
                        input bit exp_lay, input bit bp, input string name);
    pulse(ops);
    tick();
    wait_done(bp, name);
    chk({name, " beats"}, DW'(beats.size()), DW'(n));
    for (int i = 0; i < n && i < beats.size(); i++)
      chk($sformatf("%s beat%0d", name, i), beats[i], word(first + i));
    chk({name, " cnt_ftrgrp"}, DW'(cnt_ftrgrp), DW'(grp));
    chk({name, " lay_done"}, DW'(lay_done), DW'(exp_lay));
    chk({name, " grp_done"}, DW'(grp_done), DW'(!exp_lay));
    $display("op %b: %0d beats from %0d, grp %0d, lay_done %0b", ops, beats.size(), first, cnt_ftrgrp, lay_done);
  endtask

  initial begin
    vec_t va[6];
    vec_t vb[4];
    int   exp_mid[6];
    int   cyc;

    va[0] = '{3'b100, 0, 4, 0, 1'b0};
    va[1] = '{3'b010, 4, 3, 1, 1'b0};
    va[2] = '{3'b001, 4, 3, 1, 1'b0};
    va[3] = '{3'b010, 7, 3, 2, 1'b0};
    va[4] = '{3'b010, 0, 0, 2, 1'b1};
    va[5] = '{3'b100, 0, 4, 0, 1'b0};
    vb[0] = '{3'b100, 20, 4, 0, 1'b0};
    vb[1] = '{3'b011, 24, 0, 1, 1'b0};
    vb[2] = '{3'b010, 24, 9, 2, 1'b0};
    vb[3] = '{3'b110, 20, 4, 0, 1'b0};
    exp_mid = '{0, 1, 8, 9, 10, 11};

    // Reset values
    repeat (2) @(posedge clk);
    #2;
    chk("rst sram_rd_en", DW'(sram_rd_en), '0);
    chk("rst sram_rd_addr", DW'(sram_rd_addr), '0);
    chk("rst out_vld", DW'(out_vld), '0);
    chk("rst out_dat", out_dat, '0);
    chk("rst grp_done", DW'(grp_done), '0);
    chk("rst lay_done", DW'(lay_done), '0);
    chk("rst cnt_ftrgrp", DW'(cnt_ftrgrp), '0);
    tick();
    rst_n = 1'b1;
    tick();

    // Layer A: tab = {0,4,7,10}, 3 groups; idle issues nothing
    set_tab(0, 4, 7, 10, 3);
    tick(); tick();
    chk("idle sram_rd_en", DW'(sram_rd_en), '0);

    // Latency from an accepted Reset_FtrLay
    Reset_FtrLay = 1'b1;
    tick();
    Reset_FtrLay = 1'b0;
    chk("lat rd_en N+1", DW'(sram_rd_en), DW'(1));
    chk("lat rd_addr N+1", DW'(sram_rd_addr), DW'(0));
    chk("lat out_vld N+1", DW'(out_vld), '0);
    tick();
    chk("lat rd_addr N+2", DW'(sram_rd_addr), DW'(1));
    chk("lat out_vld N+2", DW'(out_vld), '0);
    tick();
    chk("lat out_vld N+3", DW'(out_vld), DW'(1));
    chk("lat out_dat N+3", out_dat, word(0));
    wait_done(1'b0, "lat");

    for (int i = 0; i < 6; i++)
      run_op(va[i].ops, va[i].first, va[i].n, va[i].grp, va[i].lay, 1'b0, $sformatf("A%0d", i));

    // Mid-stream advance after exactly two beats of group 0
    set_tab(0, 8, 12, 12, 2);
    out_rdy = 1'b0;
    pulse(3'b100);
    repeat (5) tick();
    out_rdy = 1'b1;
    tick(); tick();
    out_rdy = 1'b0;
    Next_FtrGrp = 1'b1;
    tick();
    Next_FtrGrp = 1'b0;
    out_rdy = 1'b1;
    tick();
    wait_done(1'b0, "mid");
    chk("mid beats", DW'(beats.size()), DW'(6));
    for (int i = 0; i < 6 && i < beats.size(); i++)
      chk($sformatf("mid beat%0d", i), beats[i], word(exp_mid[i]));
    chk("mid cnt_ftrgrp", DW'(cnt_ftrgrp), DW'(1));
    $display("mid-stream advance: %0d beats, grp %0d", beats.size(), cnt_ftrgrp);

    // Backpressure over a 6-word group
    set_tab(100, 106, 106, 106, 1);
    chk_bp = 1'b1;
    run_op(3'b100, 100, 6, 0, 1'b0, 1'b1, "bp");
    chk("bp stall stable", DW'(stall_err), '0);
    chk("bp outstanding<=2", DW'(max_out <= 2), DW'(1));
    $display("backpressure: stall errors %0d, max outstanding %0d", stall_err, max_out);
    chk_bp = 1'b0;

    // Layer B: empty group, coinciding pulses
    set_tab(20, 24, 24, 33, 3);
    for (int i = 0; i < 4; i++)
      run_op(vb[i].ops, vb[i].first, vb[i].n, vb[i].grp, vb[i].lay, 1'b0, $sformatf("B%0d", i));

    // Asynchronous reset mid-group
    set_tab(0, 4, 7, 10, 3);
    pulse(3'b100);
    cyc = 0;
    while (beats.size() < 2 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("ar beats before reset", DW'(beats.size() >= 2), DW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar sram_rd_en", DW'(sram_rd_en), '0);
    chk("ar sram_rd_addr", DW'(sram_rd_addr), '0);
    chk("ar out_vld", DW'(out_vld), '0);
    chk("ar out_dat", out_dat, '0);
    chk("ar grp_done", DW'(grp_done), '0);
    chk("ar lay_done", DW'(lay_done), '0);
    chk("ar cnt_ftrgrp", DW'(cnt_ftrgrp), '0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("ar idle rd_en", DW'(sram_rd_en), '0);
    run_op(3'b100, 0, 0, 0, 1'b0, 1'b0, "ar cleared tab");
    set_tab(0, 4, 7, 10, 3);
    run_op(3'b100, 0, 4, 0, 1'b0, 1'b0, "ar restart");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
